// File: rtl/fpu_ss_scoreboard_if.sv
// Scoreboard port bundle for the FPU subsystem.
//
// Groups every scoreboard signal except clock and reset. The controller
// side uses the master modport, the scoreboard itself uses the slave modport.
//   flush/alloc/wb/rs/chk  : hazard tracking inputs
//   dep_rs/dep_rd/fwd_*    : hazard and forwarding results
//   commit/id_query/retire : offload ID table inputs, id_ok result
//   err/stall_cnt          : sticky error flag and stall statistics
interface fpu_ss_scoreboard_if #(
  parameter int NUM_RS   = 3,
  parameter int NUM_WB   = 2,
  parameter int ID_WIDTH = 4
);
  localparam int SEL_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic                    flush_i;
  logic                    alloc_valid_i;
  logic [4:0]              alloc_rd_i;
  logic [NUM_WB-1:0]       wb_valid_i;
  logic [5*NUM_WB-1:0]     wb_rd_i;
  logic [5*NUM_RS-1:0]     rs_i;
  logic [NUM_RS-1:0]       rs_used_i;
  logic                    chk_rd_valid_i;
  logic [4:0]              chk_rd_i;
  logic                    dep_rs_o;
  logic                    dep_rd_o;
  logic [NUM_RS-1:0]       fwd_valid_o;
  logic [NUM_RS*SEL_W-1:0] fwd_sel_o;
  logic                    commit_valid_i;
  logic [ID_WIDTH-1:0]     commit_id_i;
  logic                    commit_kill_i;
  logic [ID_WIDTH-1:0]     id_query_i;
  logic                    id_ok_o;
  logic                    id_retire_valid_i;
  logic [ID_WIDTH-1:0]     id_retire_i;
  logic                    err_o;
  logic [31:0]             stall_cnt_o;

  modport master (
    output flush_i, alloc_valid_i, alloc_rd_i, wb_valid_i, wb_rd_i,
           rs_i, rs_used_i, chk_rd_valid_i, chk_rd_i,
           commit_valid_i, commit_id_i, commit_kill_i, id_query_i,
           id_retire_valid_i, id_retire_i,
    input  dep_rs_o, dep_rd_o, fwd_valid_o, fwd_sel_o, id_ok_o,
           err_o, stall_cnt_o
  );

  modport slave (
    input  flush_i, alloc_valid_i, alloc_rd_i, wb_valid_i, wb_rd_i,
           rs_i, rs_used_i, chk_rd_valid_i, chk_rd_i,
           commit_valid_i, commit_id_i, commit_kill_i, id_query_i,
           id_retire_valid_i, id_retire_i,
    output dep_rs_o, dep_rd_o, fwd_valid_o, fwd_sel_o, id_ok_o,
           err_o, stall_cnt_o
  );
endinterface

// File: rtl/fpu_ss_scoreboard.sv
// Operand / offload-ID scoreboard for the FPU subsystem.
//
// Tracks outstanding writes to each of the 32 FP registers with a small
// saturating counter, reports RAW and WAW/capacity hazards to the issue
// controller, selects a write-back port to forward from when the single
// pending write lands in the same cycle, and keeps a table of committed
// offload IDs.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   sb      : fpu_ss_scoreboard_if.slave bundle (see interface header)
//
// Build option:
//   FPU_SS_SB_STATS_EN : when defined, stall_cnt_o counts cycles with a
//                        hazard (saturating); otherwise it is tied to 0.
module fpu_ss_scoreboard #(
  parameter int NUM_RS    = 3,
  parameter int NUM_WB    = 2,
  parameter int CNT_WIDTH = 2,
  parameter int ID_WIDTH  = 4,
  parameter int ALLOW_WAW = 0
) (
  input logic                clk_i,
  input logic                rst_ni,
  fpu_ss_scoreboard_if.slave sb
);

  localparam int SEL_W   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int NUM_IDS = 2 ** ID_WIDTH;
  localparam int CNT_MAX = (2 ** CNT_WIDTH) - 1;

  logic [CNT_WIDTH-1:0] cnt_q [32];
  logic [CNT_WIDTH-1:0] cnt_d [32];
  int                   rel_n [32];
  logic                 err_q;
  logic                 err_d;
  logic [NUM_IDS-1:0]   id_q;
  logic [NUM_IDS-1:0]   id_d;
  logic                 commit_set;
  logic                 dep_rs;
  logic                 dep_rd;
  logic [NUM_RS-1:0]       fwd_valid;
  logic [NUM_RS*SEL_W-1:0] fwd_sel;
  int                   eff_chk;

  // Number of write-backs landing on each register this cycle; several
  // ports may target the same register.
  always_comb begin : release_count
    for (int r = 0; r < 32; r++) begin
      rel_n[r] = 0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (sb.wb_valid_i[k] && (sb.wb_rd_i[5*k +: 5] == 5'(r))) begin
          rel_n[r] = rel_n[r] + 1;
        end
      end
    end
  end

  // Counter next state: add the allocation, subtract releases. Underflow
  // clamps to zero and overflow holds the old value; both raise err.
  always_comb begin : counter_next
    int alloc_n;
    int avail;
    err_d   = 1'b0;
    alloc_n = 0;
    avail   = 0;
    for (int r = 0; r < 32; r++) begin
      alloc_n  = (sb.alloc_valid_i && (sb.alloc_rd_i == 5'(r))) ? 1 : 0;
      avail    = int'(cnt_q[r]) + alloc_n;
      cnt_d[r] = cnt_q[r];
      if (rel_n[r] > avail) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if ((avail - rel_n[r]) > CNT_MAX) begin
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_WIDTH'(avail - rel_n[r]);
      end
      if (sb.flush_i) begin
        cnt_d[r] = '0;
      end
    end
  end

  // RAW check. A single pending write that is being written back this
  // cycle is not a hazard: the operand is forwarded from the lowest
  // matching write-back port instead.
  always_comb begin : raw_check
    logic [4:0]       src;
    logic             hit;
    logic [SEL_W-1:0] sel;
    dep_rs    = 1'b0;
    fwd_valid = '0;
    fwd_sel   = '0;
    src       = '0;
    hit       = 1'b0;
    sel       = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      src = sb.rs_i[5*i +: 5];
      hit = 1'b0;
      sel = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (sb.wb_valid_i[k] && (sb.wb_rd_i[5*k +: 5] == src)) begin
          hit = 1'b1;
          sel = SEL_W'(k);
        end
      end
      if (sb.rs_used_i[i] && (cnt_q[src] != '0)) begin
        if ((cnt_q[src] == CNT_WIDTH'(1)) && hit) begin
          fwd_valid[i]             = 1'b1;
          fwd_sel[i*SEL_W +: SEL_W] = sel;
        end else begin
          dep_rs = 1'b1;
        end
      end
    end
  end

  // WAW check on the effective count (registered count minus this
  // cycle's releases). With overlap allowed only saturation stalls.
  always_comb begin : waw_check
    eff_chk = int'(cnt_q[sb.chk_rd_i]) - rel_n[sb.chk_rd_i];
    dep_rd  = 1'b0;
    if (sb.chk_rd_valid_i) begin
      if (ALLOW_WAW != 0) begin
        dep_rd = (eff_chk == CNT_MAX);
      end else begin
        dep_rd = (eff_chk != 0);
      end
    end
  end

  // ID table: a clear from retire is overridden by a commit of the same
  // ID in the same cycle, since that ID has just been reused.
  assign commit_set = sb.commit_valid_i & ~sb.commit_kill_i;

  always_comb begin : id_next
    id_d = id_q;
    if (sb.id_retire_valid_i) begin
      id_d[sb.id_retire_i] = 1'b0;
    end
    if (commit_set) begin
      id_d[sb.commit_id_i] = 1'b1;
    end
    if (sb.flush_i) begin
      id_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : state_regs
    if (!rst_ni) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      id_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      id_q  <= id_d;
      err_q <= err_q | err_d;
    end
  end

  assign sb.dep_rs_o    = dep_rs;
  assign sb.dep_rd_o    = dep_rd;
  assign sb.fwd_valid_o = fwd_valid;
  assign sb.fwd_sel_o   = fwd_sel;
  assign sb.id_ok_o     = id_q[sb.id_query_i] |
                          (commit_set && (sb.commit_id_i == sb.id_query_i));
  assign sb.err_o       = err_q;

`ifdef FPU_SS_SB_STATS_EN
  logic [31:0] stall_q;

  // Stall statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin : stall_stats
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((dep_rs || dep_rd) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign sb.stall_cnt_o = stall_q;
`else
  assign sb.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpu_ss_scoreboard.sv
// Directed testbench for fpu_ss_scoreboard.
//
// dut_waw has ALLOW_WAW=1, dut_nowaw has ALLOW_WAW=0; both receive the same
// stimulus. Inputs change on the falling edge and outputs are sampled 1ns
// later. Counter contents are observed through the hazard outputs.
module tb_fpu_ss_scoreboard;

  logic clk_i;
  logic rst_ni;
  int   check_count;
  int   error_count;

  fpu_ss_scoreboard_if #(.NUM_RS(3), .NUM_WB(2), .ID_WIDTH(4)) sb0 ();
  fpu_ss_scoreboard_if #(.NUM_RS(3), .NUM_WB(2), .ID_WIDTH(4)) sb1 ();

  fpu_ss_scoreboard #(
    .NUM_RS(3), .NUM_WB(2), .CNT_WIDTH(2), .ID_WIDTH(4), .ALLOW_WAW(1)
  ) dut_waw (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .sb    (sb0.slave)
  );

  fpu_ss_scoreboard #(
    .NUM_RS(3), .NUM_WB(2), .CNT_WIDTH(2), .ID_WIDTH(4), .ALLOW_WAW(0)
  ) dut_nowaw (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .sb    (sb1.slave)
  );

  // The second instance mirrors every input of the first.
  assign sb1.flush_i           = sb0.flush_i;
  assign sb1.alloc_valid_i     = sb0.alloc_valid_i;
  assign sb1.alloc_rd_i        = sb0.alloc_rd_i;
  assign sb1.wb_valid_i        = sb0.wb_valid_i;
  assign sb1.wb_rd_i           = sb0.wb_rd_i;
  assign sb1.rs_i              = sb0.rs_i;
  assign sb1.rs_used_i         = sb0.rs_used_i;
  assign sb1.chk_rd_valid_i    = sb0.chk_rd_valid_i;
  assign sb1.chk_rd_i          = sb0.chk_rd_i;
  assign sb1.commit_valid_i    = sb0.commit_valid_i;
  assign sb1.commit_id_i       = sb0.commit_id_i;
  assign sb1.commit_kill_i     = sb0.commit_kill_i;
  assign sb1.id_query_i        = sb0.id_query_i;
  assign sb1.id_retire_valid_i = sb0.id_retire_valid_i;
  assign sb1.id_retire_i       = sb0.id_retire_i;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Waits for the falling edge and returns every input to idle.
  task automatic applyStimulus();
    @(negedge clk_i);
    sb0.flush_i           = 1'b0;
    sb0.alloc_valid_i     = 1'b0;
    sb0.alloc_rd_i        = '0;
    sb0.wb_valid_i        = '0;
    sb0.wb_rd_i           = '0;
    sb0.rs_i              = '0;
    sb0.rs_used_i         = '0;
    sb0.chk_rd_valid_i    = 1'b0;
    sb0.chk_rd_i          = '0;
    sb0.commit_valid_i    = 1'b0;
    sb0.commit_id_i       = '0;
    sb0.commit_kill_i     = 1'b0;
    sb0.id_query_i        = '0;
    sb0.id_retire_valid_i = 1'b0;
    sb0.id_retire_i       = '0;
  endtask

  task automatic allocReg(input logic [4:0] rd);
    applyStimulus();
    sb0.alloc_valid_i = 1'b1;
    sb0.alloc_rd_i    = rd;
  endtask

  initial begin
    logic [31:0] exp_stall;
    check_count = 0;
    error_count = 0;
    rst_ni      = 1'b0;
`ifdef FPU_SS_SB_STATS_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif

    // Reset state
    applyStimulus();
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    sb0.rs_used_i      = 3'b111;
    sb0.rs_i           = {5'd1, 5'd2, 5'd3};
    #1;
    checkOutput("rst_dep_rs", 32'(sb0.dep_rs_o), 32'd0);
    checkOutput("rst_dep_rd_waw", 32'(sb0.dep_rd_o), 32'd0);
    checkOutput("rst_dep_rd_nowaw", 32'(sb1.dep_rd_o), 32'd0);
    checkOutput("rst_fwd_valid", 32'(sb0.fwd_valid_o), 32'd0);
    checkOutput("rst_fwd_sel", 32'(sb0.fwd_sel_o), 32'd0);
    checkOutput("rst_id_ok", 32'(sb0.id_ok_o), 32'd0);
    checkOutput("rst_err", 32'(sb0.err_o), 32'd0);
    checkOutput("rst_stall", sb0.stall_cnt_o, 32'd0);
    applyStimulus();
    rst_ni = 1'b1;

    // Forwarding from write-back port 1
    allocReg(5'd5);
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd5;
    #1;
    checkOutput("fwd_pre_alloc_dep_rd", 32'(sb1.dep_rd_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i      = 3'b001;
    sb0.rs_i[4:0]      = 5'd5;
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd5;
    #1;
    checkOutput("pend1_dep_rs", 32'(sb0.dep_rs_o), 32'd1);
    checkOutput("pend1_dep_rd_nowaw", 32'(sb1.dep_rd_o), 32'd1);
    checkOutput("pend1_dep_rd_waw", 32'(sb0.dep_rd_o), 32'd0);
    applyStimulus();
    sb0.wb_valid_i     = 2'b10;
    sb0.wb_rd_i[9:5]   = 5'd5;
    sb0.rs_used_i      = 3'b001;
    sb0.rs_i[4:0]      = 5'd5;
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd5;
    #1;
    checkOutput("fwd_dep_rs", 32'(sb0.dep_rs_o), 32'd0);
    checkOutput("fwd_valid", 32'(sb0.fwd_valid_o), 32'b001);
    checkOutput("fwd_sel", 32'(sb0.fwd_sel_o), 32'b001);
    checkOutput("fwd_eff_dep_rd_nowaw", 32'(sb1.dep_rd_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i = 3'b001;
    sb0.rs_i[4:0] = 5'd5;
    #1;
    checkOutput("fwd_released", 32'(sb0.dep_rs_o), 32'd0);

    // Two outstanding writes to r7
    allocReg(5'd7);
    allocReg(5'd7);
    applyStimulus();
    sb0.rs_used_i    = 3'b001;
    sb0.rs_i[4:0]    = 5'd7;
    sb0.wb_valid_i   = 2'b01;
    sb0.wb_rd_i[4:0] = 5'd7;
    #1;
    checkOutput("two_pend_dep_rs", 32'(sb0.dep_rs_o), 32'd1);
    checkOutput("two_pend_fwd_valid", 32'(sb0.fwd_valid_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i    = 3'b010;
    sb0.rs_i[9:5]    = 5'd7;
    sb0.wb_valid_i   = 2'b01;
    sb0.wb_rd_i[4:0] = 5'd7;
    #1;
    checkOutput("two_second_dep_rs", 32'(sb0.dep_rs_o), 32'd0);
    checkOutput("two_second_fwd_valid", 32'(sb0.fwd_valid_o), 32'b010);
    checkOutput("two_second_fwd_sel", 32'(sb0.fwd_sel_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i   = 3'b100;
    sb0.rs_i[14:10] = 5'd7;
    #1;
    checkOutput("two_drained", 32'(sb0.dep_rs_o), 32'd0);

    // Same-cycle alloc plus two releases on r3
    allocReg(5'd3);
    allocReg(5'd3);
    applyStimulus();
    sb0.alloc_valid_i = 1'b1;
    sb0.alloc_rd_i    = 5'd3;
    sb0.wb_valid_i    = 2'b11;
    sb0.wb_rd_i       = {5'd3, 5'd3};
    sb0.rs_used_i     = 3'b001;
    sb0.rs_i[4:0]     = 5'd3;
    #1;
    checkOutput("mix_cnt2_dep_rs", 32'(sb0.dep_rs_o), 32'd1);
    applyStimulus();
    sb0.alloc_valid_i = 1'b1;
    sb0.alloc_rd_i    = 5'd3;
    sb0.wb_valid_i    = 2'b11;
    sb0.wb_rd_i       = {5'd3, 5'd3};
    sb0.rs_used_i     = 3'b001;
    sb0.rs_i[4:0]     = 5'd3;
    #1;
    checkOutput("mix_cnt1_fwd_valid", 32'(sb0.fwd_valid_o), 32'b001);
    checkOutput("mix_lowest_port", 32'(sb0.fwd_sel_o), 32'd0);
    checkOutput("mix_err", 32'(sb0.err_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i      = 3'b001;
    sb0.rs_i[4:0]      = 5'd3;
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd3;
    #1;
    checkOutput("mix_cnt0_dep_rs", 32'(sb0.dep_rs_o), 32'd0);
    checkOutput("mix_cnt0_dep_rd", 32'(sb1.dep_rd_o), 32'd0);
    checkOutput("mix_err_after", 32'(sb0.err_o), 32'd0);

    // Saturation on r9
    allocReg(5'd9);
    allocReg(5'd9);
    allocReg(5'd9);
    applyStimulus();
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    #1;
    checkOutput("sat_dep_rd", 32'(sb0.dep_rd_o), 32'd1);
    applyStimulus();
    sb0.alloc_valid_i  = 1'b1;
    sb0.alloc_rd_i     = 5'd9;
    sb0.wb_valid_i     = 2'b01;
    sb0.wb_rd_i[4:0]   = 5'd9;
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    #1;
    checkOutput("sat_eff_dep_rd", 32'(sb0.dep_rd_o), 32'd0);
    applyStimulus();
    sb0.alloc_valid_i  = 1'b1;
    sb0.alloc_rd_i     = 5'd9;
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    #1;
    checkOutput("sat_net0_dep_rd", 32'(sb0.dep_rd_o), 32'd1);
    checkOutput("sat_err_before", 32'(sb0.err_o), 32'd0);
    applyStimulus();
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    #1;
    checkOutput("sat_err", 32'(sb0.err_o), 32'd1);
    checkOutput("sat_hold", 32'(sb0.dep_rd_o), 32'd1);

    // Asynchronous reset in the middle of a cycle
    applyStimulus();
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd9;
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_err", 32'(sb0.err_o), 32'd0);
    checkOutput("async_rst_cnt", 32'(sb1.dep_rd_o), 32'd0);
    applyStimulus();
    rst_ni = 1'b1;

    // Release of an empty counter
    applyStimulus();
    sb0.wb_valid_i   = 2'b10;
    sb0.wb_rd_i[9:5] = 5'd12;
    #1;
    checkOutput("underflow_err_before", 32'(sb0.err_o), 32'd0);
    applyStimulus();
    sb0.rs_used_i = 3'b001;
    sb0.rs_i[4:0] = 5'd12;
    #1;
    checkOutput("underflow_err", 32'(sb0.err_o), 32'd1);
    checkOutput("underflow_clamp", 32'(sb0.dep_rs_o), 32'd0);

    // ID table
    applyStimulus();
    sb0.commit_valid_i = 1'b1;
    sb0.commit_id_i    = 4'd4;
    sb0.commit_kill_i  = 1'b1;
    sb0.id_query_i     = 4'd4;
    #1;
    checkOutput("id_kill_same", 32'(sb0.id_ok_o), 32'd0);
    applyStimulus();
    sb0.id_query_i = 4'd4;
    #1;
    checkOutput("id_kill_next", 32'(sb0.id_ok_o), 32'd0);
    applyStimulus();
    sb0.commit_valid_i = 1'b1;
    sb0.commit_id_i    = 4'd4;
    sb0.id_query_i     = 4'd4;
    #1;
    checkOutput("id_commit_same", 32'(sb0.id_ok_o), 32'd1);
    applyStimulus();
    sb0.id_query_i = 4'd4;
    #1;
    checkOutput("id_commit_reg", 32'(sb0.id_ok_o), 32'd1);
    sb0.id_query_i = 4'd5;
    #1;
    checkOutput("id_other", 32'(sb0.id_ok_o), 32'd0);
    applyStimulus();
    sb0.id_retire_valid_i = 1'b1;
    sb0.id_retire_i       = 4'd4;
    sb0.commit_valid_i    = 1'b1;
    sb0.commit_id_i       = 4'd4;
    sb0.id_query_i        = 4'd5;
    applyStimulus();
    sb0.id_query_i = 4'd4;
    #1;
    checkOutput("id_set_wins", 32'(sb0.id_ok_o), 32'd1);
    applyStimulus();
    sb0.id_retire_valid_i = 1'b1;
    sb0.id_retire_i       = 4'd4;
    sb0.id_query_i        = 4'd4;
    #1;
    checkOutput("id_retire_same", 32'(sb0.id_ok_o), 32'd1);
    applyStimulus();
    sb0.id_query_i = 4'd4;
    #1;
    checkOutput("id_retired", 32'(sb0.id_ok_o), 32'd0);

    // Flush and stall statistics
    applyStimulus();
    rst_ni = 1'b0;
    applyStimulus();
    rst_ni = 1'b1;
    allocReg(5'd1);
    sb0.commit_valid_i = 1'b1;
    sb0.commit_id_i    = 4'd6;
    allocReg(5'd2);
    allocReg(5'd3);
    for (int n = 0; n < 5; n++) begin
      applyStimulus();
      sb0.rs_used_i  = 3'b111;
      sb0.rs_i       = {5'd3, 5'd2, 5'd1};
      sb0.id_query_i = 4'd6;
      sb0.flush_i    = (n == 4);
      #1;
      checkOutput("flush_pre_dep_rs", 32'(sb0.dep_rs_o), 32'd1);
      if (n == 4) begin
        checkOutput("flush_same_id_ok", 32'(sb0.id_ok_o), 32'd1);
      end
    end
    applyStimulus();
    sb0.rs_used_i      = 3'b111;
    sb0.rs_i           = {5'd3, 5'd2, 5'd1};
    sb0.chk_rd_valid_i = 1'b1;
    sb0.chk_rd_i       = 5'd1;
    sb0.id_query_i     = 4'd6;
    #1;
    checkOutput("flush_dep_rs", 32'(sb0.dep_rs_o), 32'd0);
    checkOutput("flush_dep_rd", 32'(sb1.dep_rd_o), 32'd0);
    checkOutput("flush_id_ok", 32'(sb0.id_ok_o), 32'd0);
    checkOutput("flush_stall_cnt", sb0.stall_cnt_o, exp_stall);

    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
